// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, constants and helpers for the sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 16;

  // Quotient reported for a zero divisor: all ones in the low 'width' bits.
  function automatic logic [31:0] div_zero_quotient(input int width);
    logic [31:0] ones;
    ones = '1;
    return ones >> (32 - width);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring trial-subtraction step of the divider
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit,
  output logic             borrow
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {r_in, q_msb};
  assign trial   = shifted - {1'b0, divisor};
  assign borrow  = trial[WIDTH];
  assign q_bit   = ~borrow;

  // On a borrow, shifted < divisor, so its top bit is zero and can be dropped.
  assign r_next  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider with valid/ready handshakes
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DZ_QUOT = WIDTH'(div_zero_quotient(WIDTH));

  div_state_t     state;
  logic [WIDTH-1:0] q_reg;
  // Partial remainder is always below the divisor, so its extra top bit is never kept.
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic             step_borrow;
  logic [WIDTH-1:0] q_shift;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r_in   (r_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .divisor(dvs_reg),
    .r_next (step_r),
    .q_bit  (step_q),
    .borrow (step_borrow)
  );

  assign q_shift  = {q_reg[WIDTH-2:0], step_q};
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q_reg     <= '0;
      r_reg     <= '0;
      dvs_reg   <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvs_reg <= divisor;
            q_reg   <= dividend;
            r_reg   <= '0;
            count   <= '0;
            if (divisor == '0) begin
              quotient  <= DZ_QUOT;
              remainder <= dividend;
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          r_reg <= step_r;
          q_reg <= q_shift;
          if (count == LAST_STEP) begin
            quotient  <= q_shift;
            remainder <= step_r;
            div_zero  <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The step's quotient bit and borrow are complements by construction.
  assert property (@(posedge clk) disable iff (!rst_n) (state != CALC) || (step_q ^ step_borrow));

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_acc = 0;
  int t_first = 0;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with in_valid already driven; returns after the acceptance edge.
  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_ready && n < 60);
    in_valid = 1'b0;
    t_acc = cyc;
    check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic do_accept(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    wait_accept(tag);
  endtask

  task automatic wait_result(input string tag, input int exp_lat, input logic [W-1:0] exp_q,
                             input logic [W-1:0] exp_r, input logic exp_z);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, cyc - t_acc, exp_lat);
    check({tag, "_quotient"}, {16'd0, quotient}, {16'd0, exp_q});
    check({tag, "_remainder"}, {16'd0, remainder}, {16'd0, exp_r});
    check({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp_z});
  endtask

  // With out_ready high, the result is taken on the next edge.
  task automatic consume(input string tag);
    @(negedge clk);
    check({tag, "_out_valid_clr"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_set"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int ones;
    logic [W-1:0] rd, rs;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;

    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {16'd0, remainder}, 32'd0);
    check("rst_div_zero", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_accept("d100_7", 16'd100, 16'd7);
    wait_result("d100_7", 16, 16'd14, 16'd2, 1'b0);
    consume("d100_7");

    // Second request presented while the first result is still pending.
    do_accept("dffff_1", 16'hFFFF, 16'd1);
    t_first = t_acc;
    wait_result("dffff_1", 16, 16'hFFFF, 16'd0, 1'b0);
    dividend = 16'd3;
    divisor  = 16'd10;
    in_valid = 1'b1;
    consume("dffff_1");
    wait_accept("d3_10");
    check("initiation_interval", t_acc - t_first, 18);
    wait_result("d3_10", 16, 16'd0, 16'd3, 1'b0);
    consume("d3_10");

    do_accept("d5_0", 16'd5, 16'd0);
    wait_result("d5_0", 0, 16'hFFFF, 16'd5, 1'b1);
    consume("d5_0");

    out_ready = 1'b0;
    do_accept("dffff_ff", 16'hFFFF, 16'h00FF);
    wait_result("dffff_ff", 16, 16'h0101, 16'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_quotient", {16'd0, quotient}, 32'h0101);
      check("hold_remainder", {16'd0, remainder}, 32'd0);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    consume("dffff_ff");

    do_accept("d1000_3_rst", 16'd1000, 16'd3);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_quotient", {16'd0, quotient}, 32'd0);
    check("arst_remainder", {16'd0, remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_accept("d1000_3", 16'd1000, 16'd3);
    wait_result("d1000_3", 16, 16'd333, 16'd1, 1'b0);
    consume("d1000_3");

    do_accept("d50_5", 16'd50, 16'd5);
    repeat (3) @(negedge clk);
    dividend = 16'd9;
    divisor  = 16'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("d50_5", 16, 16'd10, 16'd0, 1'b0);
    consume("d50_5");
    ones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) ones++;
    end
    check("single_out_valid", ones, 0);

    for (int i = 0; i < 30; i++) begin
      rd = W'($urandom_range(0, 65535));
      rs = (i % 3 == 0) ? W'($urandom_range(1, 20)) : W'($urandom_range(0, 65535));
      if (i % 10 == 5) rs = '0;
      @(negedge clk);
      do_accept("rand", rd, rs);
      if (rs == '0)
        wait_result("rand", 0, 16'hFFFF, rd, 1'b1);
      else
        wait_result("rand", 16, rd / rs, rd % rs, 1'b0);
      consume("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
